// File: rtl/hex_keypad_pkg.sv
// Shared constants for the hex keypad injector: FSM state encodings and
// the split of a 4-bit key code into row and column fields.
package hex_keypad_pkg;

    // One-hot FSM encodings
    localparam int          STATE_W  = 3;
    localparam logic [2:0]  ST_IDLE  = 3'b001;
    localparam logic [2:0]  ST_PRESS = 3'b010;
    localparam logic [2:0]  ST_GAP   = 3'b100;

    // Key code layout: code[3:2] selects the row, code[1:0] the column
    localparam int CODE_W    = 4;
    localparam int FIELD_W   = 2;
    localparam int ROW_POS   = 2;
    localparam int COL_POS   = 0;
    localparam int KEY_LINES = 4;

    function automatic logic [FIELD_W-1:0] code_row(input logic [CODE_W-1:0] code);
        return code[ROW_POS +: FIELD_W];
    endfunction

    function automatic logic [FIELD_W-1:0] code_col(input logic [CODE_W-1:0] code);
        return code[COL_POS +: FIELD_W];
    endfunction

endpackage

// File: rtl/key_code_fifo.sv
// Small synchronous FIFO of key codes. Pointers wrap naturally because
// DEPTH is a power of two; the occupancy counter is one bit wider so that
// full and empty are unambiguous. push_ready depends only on occupancy.
module key_code_fifo
    import hex_keypad_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push_valid,
    input  logic [CODE_W-1:0] push_data,
    output logic              push_ready,
    input  logic              pop_req,
    output logic [CODE_W-1:0] pop_data,
    output logic              empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [CODE_W-1:0] mem_q [DEPTH];
    logic [CODE_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full;
    logic              do_push;
    logic              do_pop;

    assign full       = (count_q == CNT_W'(DEPTH));
    assign empty      = (count_q == '0);
    assign push_ready = !full;
    assign do_push    = push_valid && !full;
    assign do_pop     = pop_req && !empty;
    assign pop_data   = mem_q[rd_ptr_q];

    // Next-state: write on push, advance pointers, track occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage and pointer registers, cleared asynchronously
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/hex_key_injector.sv
// Keypad-side model of a 4x4 matrix keypad. Buffered key codes are
// "pressed" one at a time for HOLD_CYC cycles, followed by GAP_CYC released
// cycles and one IDLE cycle. While pressed, Row answers the scanner's Col.
//
// Handshake: a code transfers on a rising clock edge where In_Valid and
// In_Ready are both high; In_Ready reflects only FIFO occupancy (it is low
// whenever the FIFO is full, even if a pop happens that cycle) and never
// looks at In_Valid.
module hex_key_injector
    import hex_keypad_pkg::*;
#(
    parameter int HOLD_CYC = 64,
    parameter int GAP_CYC  = 16,
    parameter int DEPTH    = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [3:0]         Code_In,
    input  logic               In_Valid,
    output logic               In_Ready,
    input  logic [3:0]         Col,
    output logic [3:0]         Row,
    output logic               Key_Down,
    output logic [3:0]         Cur_Code,
    output logic               Done,
    output logic               Busy,
    output logic [STATE_W-1:0] dbg_state
);
    localparam int MAX_CYC = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CODE_W-1:0]  cur_code_q, cur_code_d;
    logic               fifo_pop;
    logic [CODE_W-1:0]  fifo_data;
    logic               fifo_empty;
    logic               done;

    key_code_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push_valid (In_Valid),
        .push_data  (Code_In),
        .push_ready (In_Ready),
        .pop_req    (fifo_pop),
        .pop_data   (fifo_data),
        .empty      (fifo_empty)
    );

    // Press sequencer: IDLE pops the next code, PRESS holds, GAP releases
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        cur_code_d = cur_code_q;
        fifo_pop   = 1'b0;
        done       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    cur_code_d = fifo_data;
                    count_d    = '0;
                    state_d    = ST_PRESS;
                end
            end
            ST_PRESS: begin
                if (count_q == HOLD_LAST) begin
                    done    = 1'b1;
                    count_d = '0;
                    state_d = ST_GAP;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (count_q == GAP_LAST) begin
                    count_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            default: begin
                count_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer registers; reset drops the key immediately
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            cur_code_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            cur_code_q <= cur_code_d;
        end
    end

    assign Key_Down  = (state_q == ST_PRESS);
    assign Cur_Code  = cur_code_q;
    assign Done      = done;
    assign Busy      = (state_q != ST_IDLE) || !fifo_empty;
    assign dbg_state = state_q;

    // Row decode: the pressed key shorts its column onto its row
    always_comb begin
        Row = '0;
        if (Key_Down && Col[code_col(cur_code_q)]) begin
            Row[code_row(cur_code_q)] = 1'b1;
        end
    end

endmodule

// File: tb/tb_hex_key_injector.sv
// Directed bench for hex_key_injector with default parameters.
module tb_hex_key_injector;
    import hex_keypad_pkg::*;

    localparam int HOLD  = 64;
    localparam int GAP   = 16;
    localparam int DEPTH = 4;

    logic         clock = 1'b0;
    logic         reset;
    logic [3:0]   Code_In;
    logic         In_Valid;
    logic         In_Ready;
    logic [3:0]   Col;
    logic [3:0]   Row;
    logic         Key_Down;
    logic [3:0]   Cur_Code;
    logic         Done;
    logic         Busy;
    logic [2:0]   dbg_state;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int done_cnt = 0;
    logic kd_prev = 1'b0;
    logic [3:0] exp_q[$];

    hex_key_injector #(.HOLD_CYC(HOLD), .GAP_CYC(GAP), .DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .Code_In   (Code_In),
        .In_Valid  (In_Valid),
        .In_Ready  (In_Ready),
        .Col       (Col),
        .Row       (Row),
        .Key_Down  (Key_Down),
        .Cur_Code  (Cur_Code),
        .Done      (Done),
        .Busy      (Busy),
        .dbg_state (dbg_state)
    );

    // Clock and cycle counter
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard: every new press must show the next queued code
    always @(negedge clock) begin
        if (reset) begin
            kd_prev = 1'b0;
        end else begin
            if (Done) done_cnt++;
            if (Key_Down && !kd_prev) begin
                if (exp_q.size() == 0) check_val("press_unexpected", 32'd1, 32'd0);
                else check_val("press_order", 32'(Cur_Code), 32'(exp_q.pop_front()));
            end
            kd_prev = Key_Down;
        end
    end

    // Driver: hold a code valid until accepted; returns the accept cycle
    task automatic push(input logic [3:0] code, output int acc_cyc);
        int w;
        Code_In  = code;
        In_Valid = 1'b1;
        w = 0;
        while (!In_Ready && w < 500) begin
            tick();
            w++;
        end
        check_val("push_ready", 32'(In_Ready), 32'd1);
        tick();
        acc_cyc = cyc;
        exp_q.push_back(code);
        In_Valid = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int w;
        w = 0;
        while (Busy && w < max_cyc) begin
            tick();
            w++;
        end
        check_val("idle_reached", 32'(Busy), 32'd0);
    endtask

    task automatic wait_key(input int max_cyc);
        int w;
        w = 0;
        while (!Key_Down && w < max_cyc) begin
            tick();
            w++;
        end
        check_val("key_down_seen", 32'(Key_Down), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc, acc0, acc5, bad, kd_high, done_pos, d0, kd, hits, decoded;
        logic [3:0] t3_codes[6];
        t3_codes = '{4'h3, 4'h6, 4'h9, 4'hC, 4'hF, 4'h7};

        // Reset state
        reset = 1'b1; In_Valid = 1'b0; Code_In = 4'h0; Col = 4'b1111;
        repeat (3) @(posedge clock);
        #1;
        check_val("rst_key_down", 32'(Key_Down), 32'd0);
        check_val("rst_cur_code", 32'(Cur_Code), 32'd0);
        check_val("rst_done", 32'(Done), 32'd0);
        check_val("rst_busy", 32'(Busy), 32'd0);
        check_val("rst_in_ready", 32'(In_Ready), 32'd1);
        check_val("rst_row", 32'(Row), 32'd0);
        check_val("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        reset = 1'b0;
        tick();

        // Test 1: key 0, alternating Col 0001/0010
        Col = 4'b0001;
        push(4'h0, acc);
        check_val("t1_no_bypass", 32'(Key_Down), 32'd0);
        check_val("t1_busy", 32'(Busy), 32'd1);
        bad = 0; kd_high = 0; done_pos = -1;
        for (int i = 0; i < HOLD + 2; i++) begin
            tick();
            Col = (i % 2 == 1) ? 4'b0010 : 4'b0001;
            #1;
            if (Key_Down) kd_high++;
            if (Key_Down !== (i < HOLD)) bad++;
            if (Row !== ((i < HOLD && i % 2 == 0) ? 4'b0001 : 4'b0000)) bad++;
            if (Done) done_pos = i;
            if (Done !== (i == HOLD - 1)) bad++;
        end
        check_val("t1_window_errors", 32'(bad), 32'd0);
        check_val("t1_hold_cycles", 32'(kd_high), 32'(HOLD));
        check_val("t1_done_pos", 32'(done_pos), 32'(HOLD - 1));
        check_val("t1_gap_state", 32'(dbg_state), 32'(ST_GAP));
        Col = 4'b0000;
        wait_idle(200);

        // Test 2: key B, Col sweep, Busy fall timing
        d0 = done_cnt;
        push(4'hB, acc);
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            Col = 4'b0001 << (i % 4);
            #1;
            if (Row !== ((i < HOLD && i % 4 == 3) ? 4'b0100 : 4'b0000)) bad++;
            if (!Busy) break;
        end
        check_val("t2_row_errors", 32'(bad), 32'd0);
        check_val("t2_busy_fall", 32'(cyc - acc), 32'(HOLD + GAP + 1));
        check_val("t2_done_pulses", 32'(done_cnt - d0), 32'd1);
        check_val("t2_cur_code_held", 32'(Cur_Code), 32'hB);
        Col = 4'b0000;

        // Test 3: fill the FIFO behind an active press
        push(t3_codes[0], acc0);
        for (int j = 1; j < 5; j++) push(t3_codes[j], acc);
        check_val("t3_full_not_ready", 32'(In_Ready), 32'd0);
        push(t3_codes[5], acc5);
        check_val("t3_sixth_accept", 32'(acc5 - acc0), 32'(HOLD + GAP + 3));
        wait_idle(6 * (HOLD + GAP + 1) + 50);
        check_val("t3_queue_drained", 32'(exp_q.size()), 32'd0);

        // Test 4: reset during a press of key 5 with key 8 queued
        Col = 4'b1111;
        d0 = done_cnt;
        push(4'h5, acc);
        push(4'h8, acc);
        repeat (29) tick();
        check_val("t4_row_before", 32'(Row), 32'b0010);
        #2;
        reset = 1'b1;
        #1;
        check_val("t4_row_async", 32'(Row), 32'd0);
        check_val("t4_key_down_async", 32'(Key_Down), 32'd0);
        check_val("t4_busy_async", 32'(Busy), 32'd0);
        check_val("t4_ready_async", 32'(In_Ready), 32'd1);
        check_val("t4_done_async", 32'(Done), 32'd0);
        exp_q.delete();
        tick();
        reset = 1'b0;
        kd = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (Key_Down) kd++;
        end
        check_val("t4_no_press_after", 32'(kd), 32'd0);
        check_val("t4_no_done", 32'(done_cnt - d0), 32'd0);
        check_val("t4_cur_code_cleared", 32'(Cur_Code), 32'd0);

        // Test 5: scan-decode every key 0..F
        Col = 4'b0000;
        for (int k = 0; k < 16; k++) begin
            push(4'(k), acc);
            wait_key(5);
            hits = 0; decoded = -1;
            for (int c = 0; c < 4; c++) begin
                Col = 4'b0001 << c;
                #1;
                for (int r = 0; r < 4; r++) begin
                    if (Row[r]) begin
                        hits++;
                        decoded = r * 4 + c;
                    end
                end
            end
            Col = 4'b0000;
            check_val("t5_hits", 32'(hits), 32'd1);
            check_val("t5_decode", 32'(decoded), 32'(k));
            wait_idle(200);
        end

        check_val("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
